rst_sequencer: RTL and testbench

- Parametrised multi-domain reset sequencer; successor to the single-output board reset/PLL-lock synchroniser.
- Sits after the PLL in the clocks/resets area.
- Filters PLL lock, holds all resets, then releases NUM_CH reset domains in a fixed staggered order.
- Re-enters reset on lock loss or a software reset request; reports sequence state and ready.

---
 rtl/rst_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rst_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Filters the PLL lock indication, holds every reset domain asserted for a
//   fixed time, then releases NUM_CH domains one after another in index order.
//   Loss of lock or a software reset request drops everything back to reset.
//
// Ports
//   i_sys_clk        system clock, rising edge
//   i_sys_rst_n      synchronous active-low reset, highest priority
//   i_pll_locked     PLL lock, asynchronous; double-flopped internally
//   i_sw_rst         software reset request, level, synchronous
//   o_rst            per-domain active-high reset (registered)
//   o_ready          high only in S_RUN (registered)
//   o_state          state register: 0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN
//   o_lock_loss_cnt  saturating count of lock-loss aborts
//
// Build option
//   RST_SEQ_LOCK_CNT_EN  when defined, o_lock_loss_cnt counts aborts caused by
//                        loss of synced lock; otherwise it is tied to zero.
module rst_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int LOCK_FILT      = 8,
  parameter int HOLD_CYCLES    = 25,
  parameter int STAGGER_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_pll_locked,
  input  logic              i_sw_rst,
  output logic [NUM_CH-1:0] o_rst,
  output logic              o_ready,
  output logic [1:0]        o_state,
  output logic [CNT_W-1:0]  o_lock_loss_cnt
);

  localparam int MAX_AB = (LOCK_FILT > HOLD_CYCLES) ? LOCK_FILT : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_AB > STAGGER_CYCLES) ? MAX_AB : STAGGER_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0]  rst_q, rst_d;
  logic               ready_q, ready_d;
  logic               lock_s;
  logic               abort;

  assign lock_s = sync_q[1];
  // Any non-waiting state falls back on lost lock or a software request.
  assign abort  = (state_q != S_WAIT_LOCK) && (!lock_s || i_sw_rst);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    case (state_q)
      S_WAIT_LOCK: begin
        rst_d   = '1;
        ready_d = 1'b0;
        idx_d   = '0;
        if (!lock_s || i_sw_rst) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(LOCK_FILT - 1)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          cnt_d    = '0;
          rst_d[0] = 1'b0;
          if (NUM_CH == 1) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
          cnt_d = '0;
          // Clearing via mask keeps released channels released.
          rst_d = rst_q & ~(NUM_CH'(1) << idx_q);
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = S_RUN;
            ready_d = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ; // S_RUN: hold outputs until an abort
    endcase
    // Abort overrides any release step or advance decided above.
    if (abort) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state_q <= S_WAIT_LOCK;
      sync_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], i_pll_locked};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

`ifdef RST_SEQ_LOCK_CNT_EN
  logic [CNT_W-1:0] llc_q, llc_d;

  // Lock loss counts once even when a software request coincides.
  always_comb begin
    llc_d = llc_q;
    if (abort && !lock_s && (llc_q != '1)) llc_d = llc_q + 1'b1;
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) llc_q <= '0;
    else              llc_q <= llc_d;
  end

  assign o_lock_loss_cnt = llc_q;
`else
  assign o_lock_loss_cnt = '0;
`endif

  assign o_rst   = rst_q;
  assign o_ready = ready_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: a default-parameter instance plus a
// NUM_CH=1 / LOCK_FILT=1 / HOLD_CYCLES=1 instance sharing the inputs.
// Edge numbering: an input changed after edge 0 is first sampled on edge 1.
module tb_rst_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, lock, sw;
  logic [3:0]  rst;
  logic        rdy;
  logic [1:0]  st;
  logic [15:0] llc;
  logic [0:0]  rst1;
  logic        rdy1;
  logic [1:0]  st1;
  logic [15:0] llc1;

  int checks = 0;
  int errors = 0;

`ifdef RST_SEQ_LOCK_CNT_EN
  localparam logic [15:0] LLC_ONE = 16'd1;
`else
  localparam logic [15:0] LLC_ONE = 16'd0;
`endif

  rst_sequencer dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_pll_locked(lock), .i_sw_rst(sw),
    .o_rst(rst), .o_ready(rdy), .o_state(st), .o_lock_loss_cnt(llc)
  );

  rst_sequencer #(.NUM_CH(1), .LOCK_FILT(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut1 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_pll_locked(lock), .i_sw_rst(sw),
    .o_rst(rst1), .o_ready(rdy1), .o_state(st1), .o_lock_loss_cnt(llc1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until o_ready or limit; reports first edge of each event (-1 = never).
  task automatic measure(input int limit, output int f0, output int f1, output int f2,
                         output int f3, output int rd, output int he, output int re,
                         output int nonmono);
    logic [3:0] prev;
    f0 = -1; f1 = -1; f2 = -1; f3 = -1; rd = -1; he = -1; re = -1; nonmono = 0;
    prev = rst;
    for (int n = 1; n <= limit; n++) begin
      step();
      if (f0 < 0 && !rst[0]) f0 = n;
      if (f1 < 0 && !rst[1]) f1 = n;
      if (f2 < 0 && !rst[2]) f2 = n;
      if (f3 < 0 && !rst[3]) f3 = n;
      if (he < 0 && st == 2'd1) he = n;
      if (re < 0 && st == 2'd2) re = n;
      if (|(rst & ~prev)) nonmono = 1;
      prev = rst;
      if (rdy) begin
        rd = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock = 1'b0; sw = 1'b0;
    repeat (4) step();
    checks++; if (rst !== 4'hF) begin errors++; $display("FAIL reset_rst got %h want f", rst); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rdy); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st); end
    checks++; if (llc !== 16'd0) begin errors++; $display("FAIL reset_llc got %0d want 0", llc); end
    checks++; if (rst1 !== 1'b1) begin errors++; $display("FAIL reset_rst1 got %b want 1", rst1); end
  endtask

  task automatic test_boot();
    int f0, f1, f2, f3, rd, he, re, nm;
    rst_n = 1'b1; lock = 1'b1;
    measure(120, f0, f1, f2, f3, rd, he, re, nm);
    checks++; if (he !== 10) begin errors++; $display("FAIL boot_hold_edge got %0d want 10", he); end
    checks++; if (re !== 35) begin errors++; $display("FAIL boot_release_edge got %0d want 35", re); end
    checks++; if (f0 !== 35) begin errors++; $display("FAIL boot_ch0 got %0d want 35", f0); end
    checks++; if (f1 !== 51) begin errors++; $display("FAIL boot_ch1 got %0d want 51", f1); end
    checks++; if (f2 !== 67) begin errors++; $display("FAIL boot_ch2 got %0d want 67", f2); end
    checks++; if (f3 !== 83) begin errors++; $display("FAIL boot_ch3 got %0d want 83", f3); end
    checks++; if (rd !== 83) begin errors++; $display("FAIL boot_ready got %0d want 83", rd); end
    checks++; if (st !== 2'd3) begin errors++; $display("FAIL boot_state got %0d want 3", st); end
    checks++; if (nm !== 0) begin errors++; $display("FAIL boot_monotonic got %0d want 0", nm); end
  endtask

  task automatic test_glitch();
    int f0, f1, f2, f3, rd, he, re, nm;
    rst_n = 1'b0; lock = 1'b0;
    repeat (2) step();
    rst_n = 1'b1; lock = 1'b1;
    repeat (5) step();
    lock = 1'b0;
    step();
    checks++; if (st !== 2'd0 || rst !== 4'hF) begin errors++;
      $display("FAIL glitch_filtered got st=%0d rst=%h want st=0 rst=f", st, rst); end
    lock = 1'b1;
    measure(120, f0, f1, f2, f3, rd, he, re, nm);
    checks++; if (he !== 10) begin errors++; $display("FAIL glitch_hold_edge got %0d want 10", he); end
    checks++; if (f0 !== 35) begin errors++; $display("FAIL glitch_ch0 got %0d want 35", f0); end
    checks++; if (rd !== 83) begin errors++; $display("FAIL glitch_ready got %0d want 83", rd); end
  endtask

  task automatic test_lock_loss();
    int f0, f1, f2, f3, rd, he, re, nm;
    lock = 1'b0;
    step();
    lock = 1'b1;
    checks++; if (rst !== 4'h0 || rdy !== 1'b1) begin errors++;
      $display("FAIL loss_edge1 got rst=%h rdy=%b want rst=0 rdy=1", rst, rdy); end
    step();
    checks++; if (rst !== 4'h0) begin errors++; $display("FAIL loss_edge2 got %h want 0", rst); end
    step();
    checks++; if (rst !== 4'hF) begin errors++; $display("FAIL loss_edge3_rst got %h want f", rst); end
    checks++; if (rdy !== 1'b0 || st !== 2'd0) begin errors++;
      $display("FAIL loss_edge3_state got rdy=%b st=%0d want rdy=0 st=0", rdy, st); end
    checks++; if (llc !== LLC_ONE) begin errors++; $display("FAIL loss_count got %0d want %0d", llc, LLC_ONE); end
    measure(120, f0, f1, f2, f3, rd, he, re, nm);
    checks++; if (he !== 8) begin errors++; $display("FAIL loss_hold_edge got %0d want 8", he); end
    checks++; if (f0 !== 33) begin errors++; $display("FAIL loss_ch0 got %0d want 33", f0); end
    checks++; if (f3 !== 81) begin errors++; $display("FAIL loss_ch3 got %0d want 81", f3); end
    checks++; if (rd !== 81) begin errors++; $display("FAIL loss_ready got %0d want 81", rd); end
    checks++; if (nm !== 0) begin errors++; $display("FAIL loss_monotonic got %0d want 0", nm); end
  endtask

  task automatic test_sw_rst();
    int f0, f1, f2, f3, rd, he, re, nm;
    int n1;
    sw = 1'b1;
    step();
    sw = 1'b0;
    checks++; if (rst !== 4'hF || st !== 2'd0 || rdy !== 1'b0) begin errors++;
      $display("FAIL sw_run_abort got rst=%h st=%0d rdy=%b want f/0/0", rst, st, rdy); end
    n1 = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (!rst[1]) begin n1 = n; break; end
    end
    checks++; if (n1 !== 49) begin errors++; $display("FAIL sw_ch1_edge got %0d want 49", n1); end
    repeat (3) step();
    checks++; if (st !== 2'd2 || rst !== 4'b1100) begin errors++;
      $display("FAIL sw_mid_release got st=%0d rst=%h want st=2 rst=c", st, rst); end
    sw = 1'b1;
    step();
    sw = 1'b0;
    checks++; if (rst !== 4'hF || st !== 2'd0) begin errors++;
      $display("FAIL sw_abort got rst=%h st=%0d want f/0", rst, st); end
    checks++; if (llc !== LLC_ONE) begin errors++; $display("FAIL sw_count got %0d want %0d", llc, LLC_ONE); end
    measure(120, f0, f1, f2, f3, rd, he, re, nm);
    checks++; if (f0 !== 33) begin errors++; $display("FAIL sw_rerelease got %0d want 33", f0); end
    checks++; if (rd !== 81) begin errors++; $display("FAIL sw_ready got %0d want 81", rd); end
  endtask

  task automatic test_midrel_rst();
    int f0, f1, f2, f3, rd, he, re, nm;
    int seen;
    sw = 1'b1;
    step();
    sw = 1'b0;
    seen = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (st == 2'd2) begin seen = 1; break; end
    end
    repeat (5) step();
    checks++; if (seen !== 1 || st !== 2'd2) begin errors++;
      $display("FAIL midrel_reach got seen=%0d st=%0d want 1/2", seen, st); end
    rst_n = 1'b0;
    step();
    checks++; if (rst !== 4'hF || rdy !== 1'b0 || st !== 2'd0) begin errors++;
      $display("FAIL midrel_reset got rst=%h rdy=%b st=%0d want f/0/0", rst, rdy, st); end
    checks++; if (llc !== 16'd0) begin errors++; $display("FAIL midrel_llc got %0d want 0", llc); end
    rst_n = 1'b1;
    measure(120, f0, f1, f2, f3, rd, he, re, nm);
    checks++; if (f0 !== 35) begin errors++; $display("FAIL midrel_ch0 got %0d want 35", f0); end
    checks++; if (rd !== 83) begin errors++; $display("FAIL midrel_ready got %0d want 83", rd); end
  endtask

  task automatic test_single();
    int er, ey, eh;
    rst_n = 1'b0; lock = 1'b0;
    repeat (2) step();
    checks++; if (rst1 !== 1'b1 || rdy1 !== 1'b0) begin errors++;
      $display("FAIL single_reset got rst=%b rdy=%b want 1/0", rst1, rdy1); end
    rst_n = 1'b1; lock = 1'b1;
    er = -1; ey = -1; eh = -1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (er < 0 && !rst1[0]) er = n;
      if (ey < 0 && rdy1) ey = n;
      if (eh < 0 && st1 == 2'd1) eh = n;
    end
    checks++; if (eh !== 3) begin errors++; $display("FAIL single_hold got %0d want 3", eh); end
    checks++; if (er !== 4) begin errors++; $display("FAIL single_rst got %0d want 4", er); end
    checks++; if (ey !== 4) begin errors++; $display("FAIL single_ready got %0d want 4", ey); end
    checks++; if (st1 !== 2'd3) begin errors++; $display("FAIL single_state got %0d want 3", st1); end
  endtask

  initial begin
    rst_n = 1'b0; lock = 1'b0; sw = 1'b0;
    test_reset();
    test_boot();
    test_glitch();
    test_lock_loss();
    test_sw_rst();
    test_midrel_rst();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
